j202_wbs_bridge: RTL and testbench
==================================

# j202_wbs_bridge

Wishbone classic slave bridge between the Caravel management SoC's Wishbone master and the J202 SoC core's internal request/ready bus. It decodes the user-project address window, converts each single Wishbone access into one handshaked core-bus transaction, and returns read data and acknowledge. A per-transaction timeout guarantees the management SoC never stalls: if the core-bus target does not respond in time, the bridge acknowledges with an error pattern and raises a sticky error flag.

## Interface
Parameters:
- BASE_ADDR, 8'h30, match value for wbs_adr_i[31:24]
- TIMEOUT, 255, maximum cycles bus_req_o stays high without bus_rdy_i (1..255)
- ERR_DATA, 32'hDEAD_BEEF, wbs_dat_o value returned on a timed-out read

Ports (single clock wb_clk_i; wb_rst_i is synchronous, active-high):
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge, single-cycle pulse
- wbs_dat_o  out  32  read data
- bus_req_o  out  1  core-bus request
- bus_we_o  out  1  core-bus write
- bus_adr_o  out  24  core-bus address = latched wbs_adr_i[23:0]
- bus_be_o  out  4  latched wbs_sel_i
- bus_wdat_o  out  32  latched wbs_dat_i
- bus_rdy_i  in  1  core-bus target completion
- bus_rdat_i  in  32  core-bus read data, valid with bus_rdy_i
- err_clr_i  in  1  clears err_o
- err_o  out  1  sticky timeout flag

## Operation
- States: IDLE, REQ, ACK.
- IDLE: hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR). On hit: latch we/adr/sel/dat into bus_* registers, set bus_req_o, clear timeout counter, go REQ. Non-hit strobes are ignored (no ack; other slaves own them).
- REQ: bus_req_o and all bus_* outputs held stable.
  - bus_rdy_i = 1: drop bus_req_o; if read, load wbs_dat_o <= bus_rdat_i; if write, wbs_dat_o <= 0; assert wbs_ack_o; go ACK.
  - else counter increments; when counter == TIMEOUT-1 and bus_rdy_i = 0: drop bus_req_o, wbs_dat_o <= ERR_DATA (read) or 0 (write), assert wbs_ack_o, set err_o, go ACK.
  - bus_rdy_i and timeout in the same cycle: bus_rdy_i wins, no error.
  - wbs_cyc_i falls while in REQ (master abort): transaction continues to completion/timeout on the core bus, but wbs_ack_o is suppressed (err_o still set on timeout); return to IDLE instead of ACK.
- ACK: wbs_ack_o high exactly this one cycle; next state IDLE unconditionally. A strobe still present in the first IDLE cycle is treated as a new transaction (back-to-back allowed).
- Counter: 8 bits, saturating is not required since TIMEOUT <= 255 bounds it.
- err_o: set on timeout, cleared by err_clr_i; set and clear in the same cycle -> set wins.
- bus_rdy_i outside REQ is ignored.

## Timing
- All outputs registered. Reset values: wbs_ack_o=0, wbs_dat_o=0, bus_req_o=0, bus_we_o=0, bus_adr_o=0, bus_be_o=0, bus_wdat_o=0, err_o=0; state IDLE; counter 0.
- Hit sampled at edge 0 -> bus_req_o high from edge 0 output (cycle 1).
- bus_rdy_i sampled high at edge k -> wbs_ack_o and wbs_dat_o valid in cycle k+1, bus_req_o low in cycle k+1.
- Minimum Wishbone latency: stb cycle 0, req cycle 1, rdy cycle 1, ack cycle 2.
- Timeout: bus_req_o high for exactly TIMEOUT cycles, ack in the following cycle.
- wb_rst_i asserted mid-transaction: at the next edge all outputs return to reset values, no ack issued, err_o cleared.

## Test plan
- Read hit, target rdy in first REQ cycle with bus_rdat_i=32'h1234_5678 at adr 32'h3000_0010 -> bus_adr_o=24'h000010, ack in cycle 2 with wbs_dat_o=32'h1234_5678, ack one cycle.
- Write 32'hA5A5_A5A5, sel 4'b0011, rdy after 5 cycles -> bus_we_o=1, bus_be_o=4'b0011, bus_wdat_o stable for 5 cycles, ack one cycle later, wbs_dat_o=0.
- Read with no bus_rdy_i, TIMEOUT=255 -> bus_req_o high 255 cycles, ack with 32'hDEAD_BEEF, err_o=1; err_clr_i pulse -> err_o=0; simultaneous new timeout and err_clr_i -> err_o stays 1.
- Access to 32'h2000_0000 -> no bus_req_o, no ack; rdy coinciding with timeout cycle -> normal data, err_o=0.
- Master drops cyc in REQ -> no ack, bus_req_o held until rdy, state IDLE afterwards; back-to-back strobe right after ack -> second transaction starts.
- wb_rst_i asserted during REQ -> next cycle bus_req_o=0, wbs_ack_o=0, err_o=0, state IDLE.

Source files
------------

// File: rtl/j202_wbs_bridge.sv
// Wishbone classic slave to J202 core request/ready bus bridge.
// One core-bus transaction per Wishbone access, with a per-transaction timeout that still acks.
module j202_wbs_bridge #(
  parameter logic [7:0]  BASE_ADDR = 8'h30,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [23:0] bus_adr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdat_o,
  input  logic        bus_rdy_i,
  input  logic [31:0] bus_rdat_i,
  input  logic        err_clr_i,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       aborted;
  logic       hit;
  logic       abort_now;
  logic       tmo;

  assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR);
  // The master may drop cyc at any point during REQ; remember it until completion.
  assign abort_now = aborted | ~wbs_cyc_i;
  assign tmo       = (cnt == CNT_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      aborted    <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      bus_req_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_adr_o  <= '0;
      bus_be_o   <= '0;
      bus_wdat_o <= '0;
      err_o      <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      // A timeout in the same cycle overrides this clear below.
      if (err_clr_i) err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            bus_we_o   <= wbs_we_i;
            bus_adr_o  <= wbs_adr_i[23:0];
            bus_be_o   <= wbs_sel_i;
            bus_wdat_o <= wbs_dat_i;
            bus_req_o  <= 1'b1;
            cnt        <= '0;
            aborted    <= 1'b0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (!wbs_cyc_i) aborted <= 1'b1;
          if (bus_rdy_i || tmo) begin
            bus_req_o <= 1'b0;
            if (bus_we_o) wbs_dat_o <= '0;
            else          wbs_dat_o <= bus_rdy_i ? bus_rdat_i : ERR_DATA;
            if (!bus_rdy_i) err_o <= 1'b1;
            if (abort_now) begin
              state <= IDLE;
            end else begin
              wbs_ack_o <= 1'b1;
              state     <= ACK;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_j202_wbs_bridge.sv
// Directed bench for j202_wbs_bridge: reads, writes, timeout, abort, decode miss, reset.
module tb_j202_wbs_bridge;
  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, rdy, clr;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic        ack, req, bwe, err;
  logic [31:0] dat, bwdat;
  logic [23:0] badr;
  logic [3:0]  bbe;
  int errs = 0;
  int nchk = 0;
  int n;

  j202_wbs_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat),
    .bus_req_o(req), .bus_we_o(bwe), .bus_adr_o(badr), .bus_be_o(bbe), .bus_wdat_o(bwdat),
    .bus_rdy_i(rdy), .bus_rdat_i(rdat), .err_clr_i(clr), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    cyc = 1; stb = 1; we = w; adr = a; sel = s; wdat = d;
  endtask

  task automatic idle_bus();
    cyc = 0; stb = 0; we = 0;
  endtask

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; rdy = 0; clr = 0;
    sel = 0; adr = 0; wdat = 0; rdat = 0;
    tick(); tick();
    chk("rst_ack", ack, 0);  chk("rst_dat", dat, 0);  chk("rst_req", req, 0);
    chk("rst_we", bwe, 0);   chk("rst_adr", badr, 0); chk("rst_be", bbe, 0);
    chk("rst_wdat", bwdat, 0); chk("rst_err", err, 0);
    rst = 0; tick();

    // Read hit, target ready in the first REQ cycle.
    start(0, 32'h3000_0010, 4'hF, 0);
    tick();
    chk("rd_req", req, 1); chk("rd_adr", badr, 24'h000010); chk("rd_we", bwe, 0); chk("rd_ack0", ack, 0);
    rdy = 1; rdat = 32'h1234_5678;
    tick();
    chk("rd_ack", ack, 1); chk("rd_dat", dat, 32'h1234_5678); chk("rd_req_lo", req, 0);
    idle_bus(); rdy = 0;
    tick();
    chk("rd_ack_pulse", ack, 0);

    // Write, target ready after several cycles.
    start(1, 32'h3000_0020, 4'b0011, 32'hA5A5_A5A5);
    tick();
    chk("wr_req", req, 1); chk("wr_we", bwe, 1); chk("wr_be", bbe, 4'b0011); chk("wr_adr", badr, 24'h000020);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wr_hold_req", req, 1); chk("wr_hold_wdat", bwdat, 32'hA5A5_A5A5); chk("wr_hold_ack", ack, 0);
    end
    rdy = 1;
    tick();
    chk("wr_ack", ack, 1); chk("wr_dat", dat, 0); chk("wr_req_lo", req, 0);
    idle_bus(); rdy = 0;
    tick();
    chk("wr_ack_pulse", ack, 0);

    // Read timeout: req high exactly 255 cycles, then ack with error data.
    start(0, 32'h3000_0040, 4'hF, 0);
    tick();
    n = 0;
    while (req === 1'b1 && n < 400) begin
      chk("to_noack", ack, 0);
      n++;
      tick();
    end
    chk("to_cycles", n, 255);
    chk("to_ack", ack, 1); chk("to_dat", dat, 32'hDEAD_BEEF); chk("to_err", err, 1);
    idle_bus();
    tick();
    chk("to_ack_pulse", ack, 0); chk("to_err_sticky", err, 1);
    clr = 1; tick(); clr = 0;
    chk("err_clr", err, 0);

    // Timeout while err_clr_i held: set wins.
    clr = 1;
    start(0, 32'h3000_0044, 4'hF, 0);
    tick();
    n = 0;
    while (req === 1'b1 && n < 400) begin n++; tick(); end
    chk("to2_cycles", n, 255);
    chk("to2_ack", ack, 1); chk("to2_err_setwins", err, 1);
    clr = 0; idle_bus();
    tick();
    chk("to2_err_hold", err, 1);

    // Reset during REQ (err_o currently set).
    start(0, 32'h3000_0050, 4'hF, 0);
    tick();
    chk("rr_req", req, 1);
    rst = 1; rdy = 1; rdat = 32'h1111_2222;
    tick();
    chk("rr_req", req, 0); chk("rr_ack", ack, 0); chk("rr_err", err, 0); chk("rr_adr", badr, 0);
    rst = 0; rdy = 0; idle_bus();
    tick();
    chk("rr_noack", ack, 0); chk("rr_idle_req", req, 0);

    // Decode miss.
    start(0, 32'h2000_0000, 4'hF, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("miss_req", req, 0); chk("miss_ack", ack, 0);
    end
    idle_bus();
    tick();

    // Ready on the timeout cycle: normal completion.
    start(0, 32'h3000_0060, 4'hF, 0);
    tick();
    for (int i = 0; i < 254; i++) tick();
    chk("edge_req", req, 1); chk("edge_noack", ack, 0);
    rdy = 1; rdat = 32'hCAFE_F00D;
    tick();
    chk("edge_ack", ack, 1); chk("edge_dat", dat, 32'hCAFE_F00D); chk("edge_err", err, 0);
    idle_bus(); rdy = 0;
    tick();

    // Master abort: req held until ready, no ack.
    start(0, 32'h3000_0070, 4'hF, 0);
    tick();
    chk("ab_req", req, 1);
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_hold_req", req, 1); chk("ab_noack", ack, 0);
    end
    rdy = 1; rdat = 32'h5555_AAAA;
    tick();
    chk("ab_req_lo", req, 0); chk("ab_noack2", ack, 0);
    rdy = 0;
    tick();
    chk("ab_noack3", ack, 0);

    // Back-to-back: strobe held through ack starts a second transaction.
    start(0, 32'h3000_0080, 4'hF, 0);
    tick();
    chk("bb1_req", req, 1);
    rdy = 1; rdat = 32'h0BAD_F00D;
    tick();
    chk("bb1_ack", ack, 1); chk("bb1_dat", dat, 32'h0BAD_F00D);
    rdy = 0; adr = 32'h3000_0084;
    tick();
    chk("bb_gap_ack", ack, 0); chk("bb_gap_req", req, 0);
    tick();
    chk("bb2_req", req, 1); chk("bb2_adr", badr, 24'h000084);
    rdy = 1; rdat = 32'h7777_8888;
    tick();
    chk("bb2_ack", ack, 1); chk("bb2_dat", dat, 32'h7777_8888);
    idle_bus(); rdy = 0;
    tick();
    chk("bb2_ack_pulse", ack, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
